// File: rtl/regwrite_seq.sv
// Register-file write-port sequencer: turns one writeback op into dst/src selects and write enables.
// Optional stack ops (POP/PUSH, WR_B state) are compiled only when REGWR_STACK_EN is defined.
module regwrite_seq #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [2:0] op,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       mem_read,
    output logic       reg_write,
    output logic [2:0] reg_dst_sel,
    output logic [1:0] wb_src_sel,
    output logic [2:0] dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MEM_WAIT = 3'd1,
        S_WR_A     = 3'd2,
`ifdef REGWR_STACK_EN
        S_WR_B     = 3'd3,
`endif
        S_ERR      = 3'd4
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_RTYPE = 3'b001;
    localparam logic [2:0] OP_ITYPE = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_JAL   = 3'b100;
`ifdef REGWR_STACK_EN
    localparam logic [2:0] OP_POP   = 3'b101;
    localparam logic [2:0] OP_PUSH  = 3'b110;
    localparam logic [2:0] DST_SP   = 3'b011;
    localparam logic [1:0] SRC_SPU  = 2'b11;
`endif

    localparam logic [2:0] DST_RT  = 3'b000;
    localparam logic [2:0] DST_RD  = 3'b001;
    localparam logic [2:0] DST_RA  = 3'b100;
    localparam logic [1:0] SRC_ALU = 2'b00;
    localparam logic [1:0] SRC_MDR = 2'b01;
    localparam logic [1:0] SRC_PC  = 2'b10;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    state_t     state, state_nx;
    logic [2:0] op_q;
    logic [3:0] cnt, cnt_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            op_q  <= OP_NOP;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == S_IDLE && start) op_q <= op;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        busy        = (state != S_IDLE);
        done        = 1'b0;
        err         = 1'b0;
        mem_read    = 1'b0;
        reg_write   = 1'b0;
        reg_dst_sel = DST_RT;
        wb_src_sel  = SRC_ALU;
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_NOP:                     state_nx = S_IDLE;
                        OP_RTYPE, OP_ITYPE, OP_JAL: state_nx = S_WR_A;
                        OP_LOAD: begin
                            state_nx = S_MEM_WAIT;
                            cnt_nx   = WAIT_INIT;
                        end
`ifdef REGWR_STACK_EN
                        OP_PUSH:                    state_nx = S_WR_A;
                        OP_POP: begin
                            state_nx = S_MEM_WAIT;
                            cnt_nx   = WAIT_INIT;
                        end
`endif
                        default:                    state_nx = S_ERR;
                    endcase
                end
            end
            S_MEM_WAIT: begin
                mem_read = 1'b1;
                // Counter returns to 0 on exit so it is only non-zero while waiting.
                if (cnt <= 4'd1) begin
                    state_nx = S_WR_A;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_WR_A: begin
                reg_write = 1'b1;
                done      = 1'b1;
                state_nx  = S_IDLE;
                case (op_q)
                    OP_RTYPE: begin reg_dst_sel = DST_RD; wb_src_sel = SRC_ALU; end
                    OP_ITYPE: begin reg_dst_sel = DST_RT; wb_src_sel = SRC_ALU; end
                    OP_LOAD:  begin reg_dst_sel = DST_RT; wb_src_sel = SRC_MDR; end
                    OP_JAL:   begin reg_dst_sel = DST_RA; wb_src_sel = SRC_PC;  end
`ifdef REGWR_STACK_EN
                    OP_PUSH:  begin reg_dst_sel = DST_SP; wb_src_sel = SRC_SPU; end
                    OP_POP: begin
                        reg_dst_sel = DST_RT;
                        wb_src_sel  = SRC_MDR;
                        done        = 1'b0;
                        state_nx    = S_WR_B;
                    end
`endif
                    default:  begin reg_dst_sel = DST_RT; wb_src_sel = SRC_ALU; end
                endcase
            end
`ifdef REGWR_STACK_EN
            S_WR_B: begin
                reg_write   = 1'b1;
                reg_dst_sel = DST_SP;
                wb_src_sel  = SRC_SPU;
                done        = 1'b1;
                state_nx    = S_IDLE;
            end
`endif
            S_ERR: begin
                err      = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign dbg_state = state;
endmodule

// File: doc/regwrite_seq.md
# regwrite_seq

Sequencer for the register-file write port of the multicycle CPU. It accepts one writeback operation from the main control unit and drives three things: the 3-bit destination-register mux select (rt, rd, alternate, $sp = 29, $ra = 31), the writeback-source select and the register write enable. Single-write ops complete in one cycle. Loads wait a configurable memory latency first. Stack pops perform two consecutive writes (rt, then $sp).

## Interface
- MEM_WAIT, default 2: cycles between load acceptance and the memory-data writeback; legal range 1..15.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  3  operation: 000 NOP, 001 RTYPE (rd ← ALU), 010 ITYPE (rt ← ALU), 011 LOAD (rt ← MDR), 100 JAL ($ra ← PC), 101 POP (rt ← MDR, then $sp ← SP unit), 110 PUSH ($sp ← SP unit), 111 reserved.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse in the final write cycle of an op.
- err  out  1  one-cycle pulse: a reserved or disabled op was started.
- mem_read  out  1  high during every MEM_WAIT cycle.
- reg_write  out  1  register-file write enable.
- reg_dst_sel  out  3  destination mux select: 000 rt, 001 rd, 010 alternate, 011 $sp (29), 100 $ra (31).
- wb_src_sel  out  2  writeback data select: 00 ALU, 01 MDR, 10 PC, 11 SP unit.

## Operation
- Moore FSM with states IDLE, MEM_WAIT, WR_A, WR_B, ERR. All outputs decode from the state, the latched op and the wait counter. No output depends combinationally on the inputs.
- IDLE, start=1:
  - Latch op.
  - RTYPE, ITYPE, JAL, PUSH → WR_A.
  - LOAD, POP → MEM_WAIT, with the counter loaded with MEM_WAIT.
  - Reserved op → ERR.
  - NOP → stay in IDLE. No pulse.
- IDLE, start=0: stay.
- MEM_WAIT: mem_read=1. The counter decrements each cycle. When counter=1, go to WR_A.
- WR_A: reg_write=1.
  - RTYPE: dst 001, src 00.
  - ITYPE: dst 000, src 00.
  - LOAD: dst 000, src 01.
  - JAL: dst 100, src 10.
  - PUSH: dst 011, src 11.
  - POP: dst 000, src 01.
  - POP → WR_B. All other ops → IDLE with done=1.
- WR_B (POP only): reg_write=1, dst 011, src 11, done=1 → IDLE.
- ERR: err=1, reg_write=0 → IDLE.
- Idle/default output values: reg_write=0, mem_read=0, done=0, err=0, reg_dst_sel=000, wb_src_sel=00.
- The 010 alternate select is never driven by this block. It is reserved for future ops.
- start while busy is ignored. It is neither queued nor flagged.
- Counter width: 4 bits. Counter is 0 outside MEM_WAIT.

## Timing
- Reset (asynchronous, reset_n=0): state=IDLE, counter=0, latched op=000, all outputs at idle values. Reset takes effect immediately, including mid-operation. An in-progress write is abandoned and no done is produced.
- Measured from the edge that samples start=1:
  - RTYPE/ITYPE/JAL/PUSH: reg_write and done high in the following cycle. busy for 1 cycle.
  - LOAD: mem_read for MEM_WAIT cycles, then one write cycle. busy for MEM_WAIT+1 cycles.
  - POP: MEM_WAIT wait cycles, then the rt write, then the $sp write. reg_write high for 2 consecutive cycles. done only on the second. busy for MEM_WAIT+2 cycles.
  - ERR: err high in the following cycle, busy for 1 cycle.
- Back-to-back: start may be held high. The next op is accepted on the edge that returns the FSM to IDLE plus one, i.e. the first edge with state=IDLE. There is a minimum one idle cycle between ops.
- MEM_WAIT=1: exactly one MEM_WAIT cycle.

## Configuration
- REGWR_STACK_EN defined: POP and PUSH behave as described above.
- REGWR_STACK_EN undefined:
  - Ops 101 and 110 are treated as reserved: → ERR, err pulse, no write.
  - WR_B is not compiled.
  - reg_dst_sel never takes 011 and wb_src_sel never takes 11.

## Test plan
- Reset: reset_n=0 mid-POP in WR_A → all outputs idle immediately. After release, no done and busy=0.
- RTYPE: start=1, op=001 → next cycle reg_write=1, reg_dst_sel=001, wb_src_sel=00, done=1. Following cycle busy=0.
- LOAD with MEM_WAIT=2: op=011 → mem_read=1 for 2 cycles. Cycle 3: reg_write=1, dst 000, src 01, done=1.
- POP with REGWR_STACK_EN and MEM_WAIT=3: op=101 → 3 mem_read cycles, then dst 000/src 01, then dst 011/src 11 with done=1. Total of 5 busy cycles.
- Reserved op: op=111 → err=1 for one cycle, reg_write stays 0. Repeat with op=110 when REGWR_STACK_EN is undefined → same result.
- Busy rejection: JAL accepted and start re-pulsed with op=001 during the write cycle → a single write only (dst 100, src 10). No second write occurs.
